multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Control FSM for the multi-cycle RV32I core. Sequences one shared ALU, one unified instruction/data memory port and the register file across several cycles per instruction.
- Sits beside the multi-cycle datapath. Consumes opcode/funct3 from the instruction register and Zero from the ALU; drives every mux select and write enable.
- The ALU decoder stays separate; this block exports only ALUOp.

Parameters:
- CNT_W, 32: width of the retired-instruction counter `instret`.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces the FSM to FETCH.
- op  in  7  instruction[6:0] taken from the instruction register.
- funct3  in  3  instruction[14:12]; used for the branch-sense decision.
- Zero  in  1  ALU zero flag, valid in the BEQ state.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- MemWrite  out  1  memory write strobe.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load the instruction register and OldPC.
- PCWrite  out  1  load PC from the Result bus.
- RegWrite  out  1  register-file write enable.
- ResultSrc  out  2  Result mux: 00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  out  2  ALU A mux: 00 PC, 01 OldPC, 10 rs1, 11 zero.
- ALUSrcB  out  2  ALU B mux: 00 rs2, 01 imm, 10 constant 4.
- ALUOp  out  2  00 add, 01 branch compare, 10 funct-decoded.
- ImmSrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
- instret  out  CNT_W  count of retired instructions.
- illegal_op  out  1  sticky illegal-opcode flag (only when the optional feature is compiled in).

Behaviour:
- Reset (async): state=FETCH, instret=0, illegal_op=0.
- Outputs are Moore-decoded from state, except the PCWrite/IRWrite/MemWrite qualifiers listed below. Unlisted outputs are 0 (selects 00).
- ImmSrc is combinational from op, independent of state:
  - I-type for load, OP-IMM and JALR.
  - S for store; B for branch; J for JAL; U for LUI/AUIPC.
  - 000 for any other opcode.
- States and per-state outputs:
  - FETCH: mem_req, AdrSrc=0, A=00, B=10, ALUOp=00, ResultSrc=10. On mem_ready: IRWrite=1, PCWrite=1, then go to DECODE. Otherwise hold in FETCH.
  - DECODE: A=01, B=01, ALUOp=00, so ALUOut becomes OldPC+imm. Next state by op:
    - 0000011 → MEMADR; 0100011 → MEMADR
    - 0110011 → EXECUTER; 0010011 → EXECUTEI
    - 1100011 → BEQ; 1101111 → JAL; 1100111 → JALR
    - 0110111 → LUI; 0010111 → AUIPC
    - anything else → FETCH (no architectural effect).
  - MEMADR: A=10, B=01, ALUOp=00. Go to MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: mem_req, AdrSrc=1. Hold until mem_ready, then MEMWB.
  - MEMWB: ResultSrc=01, RegWrite, then FETCH.
  - MEMWRITE: mem_req, AdrSrc=1, MemWrite. Hold until mem_ready, then FETCH. MemWrite stays high every cycle while waiting; memory commits only on the mem_ready cycle.
  - EXECUTER: A=10, B=00, ALUOp=10, then ALUWB.
  - EXECUTEI: A=10, B=01, ALUOp=10, then ALUWB.
  - ALUWB: ResultSrc=00, RegWrite, then FETCH.
  - BEQ: A=10, B=00, ALUOp=01, ResultSrc=00.
    - PCWrite = taken. taken = Zero for beq/bge/bgeu (funct3 000, 101, 111); taken = !Zero for bne/blt/bltu (001, 100, 110).
    - For the 1xx funct3 codes the ALU performs slt/sltu.
    - Reserved funct3 (010, 011) → not taken.
    - Then FETCH.
  - JAL: ResultSrc=00, PCWrite, A=01, B=10, ALUOp=00, then ALUWB. rd receives OldPC+4.
  - JALR: A=10, B=01, ALUOp=00, then JALRPC.
  - JALRPC: ResultSrc=00, PCWrite (PC = rs1+imm), A=01, B=10, ALUOp=00, then ALUWB.
  - LUI: A=11, B=01, ALUOp=00, then ALUWB.
  - AUIPC: A=01, B=01, ALUOp=00, then ALUWB.
- Retirement: instret increments by 1 on the final cycle of each instruction, then wraps modulo 2^CNT_W. Final cycles are:
  - MEMWB, ALUWB and BEQ.
  - MEMWRITE with mem_ready=1.
  - An unknown-opcode DECODE does not retire.
- Cycle counts with zero wait states: R/I/LUI/AUIPC 4, load 5, store 4, branch 3, JAL 4, JALR 5. Each wait cycle adds one.
- mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
- Reset asserted mid-access drops mem_req/MemWrite asynchronously; no partial write is signalled.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined: an unknown op in DECODE, or branch funct3 010/011, goes to TRAP. TRAP is absorbing until reset, with all enables 0 and mem_req=0. illegal_op=1 from the TRAP-entry clock edge until reset.
- Undefined: no TRAP state; illegal_op is tied to 0; the behaviour above applies.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode localparams;
  - state encoding (4-bit enum: FETCH..JALRPC, TRAP);
  - ResultSrc/ALUSrcA/ALUSrcB/ALUOp/ImmSrc code constants, which the datapath muxes also use.
- One sub-module, branch_sense: a combinational funct3×Zero → taken lookup, reused by a future pipelined core.
- ImmSrc decode stays inline.

Test Plan:
- `add` (op 0110011) with mem_ready always 1 → FETCH, DECODE, EXECUTER, ALUWB; RegWrite only in cycle 4; instret 0→1.
- `lw` with mem_ready low for 2 cycles in MEMREAD → mem_req and AdrSrc=1 held 3 cycles; MEMWB on cycle 7; IRWrite pulses exactly once.
- `sw` with 1 wait cycle in FETCH and 1 in MEMWRITE → MemWrite high 2 cycles; instret increments only on the mem_ready cycle.
- Branches:
  - bne, Zero=0 → PCWrite=1 in BEQ.
  - bge, Zero=0 → PCWrite=0.
  - bgeu, Zero=1 → PCWrite=1.
- `jalr` → PCWrite in JALRPC with ResultSrc=00, then ALUWB with RegWrite; total 5 cycles.
- Opcode 0001111 → back to FETCH after DECODE, with no retire. With MC_ILLEGAL_TRAP_EN it enters TRAP and illegal_op=1. Reset asserted mid-MEMWRITE → immediate FETCH, MemWrite=0, instret=0.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path.
// Holds the opcode constants, the controller state encoding, the mux/ALU code
// constants used by both the controller and the datapath muxes, and the
// per-state Moore output table.
// No ports (package).

package rv_ctrl_pkg;

  // Base opcodes recognised by the controller
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Result mux
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU A mux
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  // ALU B mux
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALU operation class handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI,
    ALUWB, BEQ, JAL, JALR, JALRPC, LUI, AUIPC, TRAP
  } state_t;

  // Moore part of the control word; the FETCH/BEQ qualifiers are added
  // combinationally in the controller.
  typedef struct packed {
    logic       memReq;
    logic       adrSrc;
    logic       memWrite;
    logic       regWrite;
    logic       pcWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
  } ctrl_t;

  // Per-state output table; anything not set stays 0 / select 00.
  function automatic ctrl_t stateCtrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.memReq    = 1'b1;
        c.aluSrcA   = SRCA_PC;
        c.aluSrcB   = SRCB_FOUR;
        c.aluOp     = ALUOP_ADD;
        c.resultSrc = RES_ALURESULT;
      end
      DECODE: begin
        c.aluSrcA = SRCA_OLDPC;
        c.aluSrcB = SRCB_IMM;
      end
      MEMADR, JALR: begin
        c.aluSrcA = SRCA_RS1;
        c.aluSrcB = SRCB_IMM;
      end
      MEMREAD: begin
        c.memReq = 1'b1;
        c.adrSrc = 1'b1;
      end
      MEMWB: begin
        c.resultSrc = RES_DATA;
        c.regWrite  = 1'b1;
      end
      MEMWRITE: begin
        c.memReq   = 1'b1;
        c.adrSrc   = 1'b1;
        c.memWrite = 1'b1;
      end
      EXECUTER: begin
        c.aluSrcA = SRCA_RS1;
        c.aluSrcB = SRCB_RS2;
        c.aluOp   = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        c.aluSrcA = SRCA_RS1;
        c.aluSrcB = SRCB_IMM;
        c.aluOp   = ALUOP_FUNCT;
      end
      ALUWB: begin
        c.resultSrc = RES_ALUOUT;
        c.regWrite  = 1'b1;
      end
      BEQ: begin
        c.aluSrcA   = SRCA_RS1;
        c.aluSrcB   = SRCB_RS2;
        c.aluOp     = ALUOP_BRANCH;
        c.resultSrc = RES_ALUOUT;
      end
      // JAL and JALRPC both redirect PC from ALUOut while ALU forms OldPC+4 for rd
      JAL, JALRPC: begin
        c.resultSrc = RES_ALUOUT;
        c.pcWrite   = 1'b1;
        c.aluSrcA   = SRCA_OLDPC;
        c.aluSrcB   = SRCB_FOUR;
      end
      LUI: begin
        c.aluSrcA = SRCA_ZERO;
        c.aluSrcB = SRCB_IMM;
      end
      AUIPC: begin
        c.aluSrcA = SRCA_OLDPC;
        c.aluSrcB = SRCB_IMM;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_branch_sense.sv
// branch_sense: combinational branch-taken decision from funct3 and the ALU
// zero flag. For the 1xx codes the ALU has produced slt/sltu, so "less than"
// shows up as Zero=0.
// Ports:
//   funct3  in  3  branch funct3
//   zero    in  1  ALU zero flag
//   taken   out 1  branch taken (reserved codes 010/011 never taken)

module branch_sense (
  input  logic [2:0] funct3,
  input  logic       zero,
  output logic       taken
);

  // Equality-type senses take on Zero, the inverted ones on !Zero
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000, 3'b101, 3'b111: taken = zero;
      3'b001, 3'b100, 3'b110: taken = ~zero;
      default:                taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for the multi-cycle RV32I core.
// Optional feature macro: MC_ILLEGAL_TRAP_EN (unknown opcode or reserved
// branch funct3 enters an absorbing TRAP state and raises illegal_op).
// Ports:
//   clk, reset (async, active-high)
//   op, funct3, Zero, mem_ready           - decode/status inputs
//   mem_req, MemWrite, AdrSrc             - memory port control
//   IRWrite, PCWrite, RegWrite            - architectural write enables
//   ResultSrc, ALUSrcA, ALUSrcB, ALUOp    - datapath mux / ALU control
//   ImmSrc                                - immediate format (from op only)
//   instret                               - retired instruction counter
//   illegal_op                            - sticky illegal-opcode flag

module multicycle_controller
  import rv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [2:0]       ImmSrc,
  output logic [CNT_W-1:0] instret,
  output logic             illegal_op
);

  state_t state;
  state_t nextState;
  ctrl_t  ctrl;
  logic   taken;
  logic   retire;

  branch_sense u_branch_sense (
    .funct3(funct3),
    .zero  (Zero),
    .taken (taken)
  );

  // Next-state selection; mem_ready only matters in the three memory states
  always_comb begin
    nextState = state;
    case (state)
      FETCH:    if (mem_ready) nextState = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: nextState = MEMADR;
          OP_R:              nextState = EXECUTER;
          OP_IMM:            nextState = EXECUTEI;
          OP_BRANCH: begin
`ifdef MC_ILLEGAL_TRAP_EN
            nextState = (funct3 == 3'b010 || funct3 == 3'b011) ? TRAP : BEQ;
`else
            nextState = BEQ;
`endif
          end
          OP_JAL:            nextState = JAL;
          OP_JALR:           nextState = JALR;
          OP_LUI:            nextState = LUI;
          OP_AUIPC:          nextState = AUIPC;
`ifdef MC_ILLEGAL_TRAP_EN
          default:           nextState = TRAP;
`else
          default:           nextState = FETCH;
`endif
        endcase
      end
      MEMADR:   nextState = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) nextState = MEMWB;
      MEMWB:    nextState = FETCH;
      MEMWRITE: if (mem_ready) nextState = FETCH;
      EXECUTER, EXECUTEI, JAL, JALRPC, LUI, AUIPC: nextState = ALUWB;
      ALUWB:    nextState = FETCH;
      BEQ:      nextState = FETCH;
      JALR:     nextState = JALRPC;
      TRAP:     nextState = TRAP;
      default:  nextState = FETCH;
    endcase
  end

  // State register plus the registered Moore control word for the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      ctrl  <= stateCtrl(FETCH);
    end else begin
      state <= nextState;
      ctrl  <= stateCtrl(nextState);
    end
  end

  // An instruction retires on its last cycle; stores only when memory accepts
  assign retire = (state == MEMWB) || (state == ALUWB) || (state == BEQ) ||
                  ((state == MEMWRITE) && mem_ready);

  // Retired-instruction counter, wraps naturally at its width
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + CNT_W'(1);
    end
  end

  // Immediate format depends on the opcode alone
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: ImmSrc = IMM_I;
      OP_STORE:                 ImmSrc = IMM_S;
      OP_BRANCH:                ImmSrc = IMM_B;
      OP_JAL:                   ImmSrc = IMM_J;
      OP_LUI, OP_AUIPC:         ImmSrc = IMM_U;
      default:                  ImmSrc = IMM_I;
    endcase
  end

  // Write strobes are masked by reset so an interrupted access never signals a partial write
  assign mem_req   = ctrl.memReq & ~reset;
  assign MemWrite  = ctrl.memWrite & ~reset;
  assign RegWrite  = ctrl.regWrite & ~reset;
  assign IRWrite   = (state == FETCH) & mem_ready & ~reset;
  assign PCWrite   = ~reset & (ctrl.pcWrite |
                               ((state == FETCH) & mem_ready) |
                               ((state == BEQ) & taken));
  assign AdrSrc    = ctrl.adrSrc;
  assign ResultSrc = ctrl.resultSrc;
  assign ALUSrcA   = ctrl.aluSrcA;
  assign ALUSrcB   = ctrl.aluSrcB;
  assign ALUOp     = ctrl.aluOp;

`ifdef MC_ILLEGAL_TRAP_EN
  // TRAP is absorbing, so being in it is the sticky flag
  assign illegal_op = (state == TRAP);
`else
  assign illegal_op = 1'b0;
`endif

endmodule
